// File: rtl/contador_pkg.sv
// ============================================================================
// Module      : contador_pkg
// Description : Shared types and constants for the contador_vaivem_param
//               counter family: the count-mode encoding and the direction
//               flag values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package contador_pkg;

  // Count mode selected on the modo input
  typedef enum logic [1:0] {
    MODO_VAIVEM  = 2'b00,  // bounce between the endpoints
    MODO_CRESC   = 2'b01,  // count up, wrap max -> min
    MODO_DECRESC = 2'b10,  // count down, wrap min -> max
    MODO_PARADO  = 2'b11   // stopped, state holds
  } modo_t;

  // Direction flag values driven on sentido
  localparam logic SENTIDO_CRESC   = 1'b0;
  localparam logic SENTIDO_DECRESC = 1'b1;

endpackage

`default_nettype wire

// File: rtl/contador_prox.sv
// ============================================================================
// Module      : contador_prox
// Description : Purely combinational next-state logic for the
//               contador_vaivem_param counter. It produces the next counter
//               value, direction and endpoint flag from the current state,
//               the mode, the enable and the programmed limits.
// Ports       : en_i        step enable
//               modo_i      count mode (see contador_pkg::modo_t)
//               lim_min_i   lower endpoint (inclusive)
//               lim_max_i   upper endpoint (inclusive)
//               saida_i     current counter value
//               sentido_i   current direction (0 up, 1 down)
//               saida_d_o   next counter value
//               sentido_d_o next direction
//               limite_d_o  next endpoint flag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module contador_prox
  import contador_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             en_i,
  input  logic [1:0]       modo_i,
  input  logic [WIDTH-1:0] lim_min_i,
  input  logic [WIDTH-1:0] lim_max_i,
  input  logic [WIDTH-1:0] saida_i,
  input  logic             sentido_i,
  output logic [WIDTH-1:0] saida_d_o,
  output logic             sentido_d_o,
  output logic             limite_d_o
);

  modo_t            modo;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] inc;
  logic [WIDTH-1:0] dec;
  logic             fora;
  logic             sobe;

  assign modo = modo_t'(modo_i);
  assign lo   = lim_min_i;
  // An inverted range collapses onto lim_min
  assign hi   = (lim_min_i > lim_max_i) ? lim_min_i : lim_max_i;
  assign inc  = saida_i + WIDTH'(1);
  assign dec  = saida_i - WIDTH'(1);
  assign fora = (saida_i < lo) || (saida_i > hi);

  // Bounce travels up unless already sitting on the upper endpoint, and
  // turns around from the lower endpoint even if the flag still says down.
  // This keeps a mode change that lands on an endpoint from stepping out
  // of range.
  assign sobe = ((sentido_i == SENTIDO_CRESC)   && (saida_i != hi)) ||
                ((sentido_i == SENTIDO_DECRESC) && (saida_i == lo));

  always_comb begin
    saida_d_o   = saida_i;
    sentido_d_o = sentido_i;
    limite_d_o  = 1'b0;
    if (!en_i || (modo == MODO_PARADO)) begin
      // hold, endpoint flag drops
    end else if (fora) begin
      // Snap back into range without stepping
      if (modo == MODO_DECRESC) begin
        saida_d_o   = hi;
        sentido_d_o = SENTIDO_DECRESC;
      end else begin
        saida_d_o   = lo;
        sentido_d_o = SENTIDO_CRESC;
      end
    end else begin
      case (modo)
        MODO_VAIVEM: begin
          if (lo == hi) begin
            // Single-point range: value stays put and is always terminal
            limite_d_o = 1'b1;
          end else if (sobe) begin
            saida_d_o   = inc;
            sentido_d_o = (inc == hi) ? SENTIDO_DECRESC : SENTIDO_CRESC;
            limite_d_o  = (inc == hi);
          end else begin
            saida_d_o   = dec;
            sentido_d_o = (dec == lo) ? SENTIDO_CRESC : SENTIDO_DECRESC;
            limite_d_o  = (dec == lo);
          end
        end
        MODO_CRESC: begin
          sentido_d_o = SENTIDO_CRESC;
          saida_d_o   = (saida_i == hi) ? lo : inc;
          limite_d_o  = (saida_i == hi) ? (lo == hi) : (inc == hi);
        end
        MODO_DECRESC: begin
          sentido_d_o = SENTIDO_DECRESC;
          saida_d_o   = (saida_i == lo) ? hi : dec;
          limite_d_o  = (saida_i == lo) ? (lo == hi) : (dec == lo);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/contador_vaivem_param.sv
// ============================================================================
// Module      : contador_vaivem_param
// Description : Parametrised up/down counter with runtime range, selectable
//               mode (bounce, up-wrap, down-wrap, stop), enable and a
//               registered endpoint flag. All outputs are registered.
//               Optional feature macro: CONTADOR_CARGA_EN adds a synchronous
//               parallel load (carga_i / valor_carga_i) that overrides
//               en_i and modo_i.
// Ports       : clk_i          rising-edge clock
//               rst_ni         asynchronous active-low reset
//               carga_i        load strobe        (CONTADOR_CARGA_EN only)
//               valor_carga_i  value to load      (CONTADOR_CARGA_EN only)
//               en_i           step enable
//               modo_i         count mode
//               lim_min_i      lower endpoint (inclusive)
//               lim_max_i      upper endpoint (inclusive)
//               saida_o        counter value
//               sentido_o      direction (0 up, 1 down)
//               limite_o       terminal endpoint reached on last step
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module contador_vaivem_param
  import contador_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
`ifdef CONTADOR_CARGA_EN
  input  logic             carga_i,
  input  logic [WIDTH-1:0] valor_carga_i,
`endif
  input  logic             en_i,
  input  logic [1:0]       modo_i,
  input  logic [WIDTH-1:0] lim_min_i,
  input  logic [WIDTH-1:0] lim_max_i,
  output logic [WIDTH-1:0] saida_o,
  output logic             sentido_o,
  output logic             limite_o
);

  logic [WIDTH-1:0] saida_q;
  logic [WIDTH-1:0] saida_d;
  logic             sentido_q;
  logic             sentido_d;
  logic             limite_q;
  logic             limite_d;

  contador_prox #(
    .WIDTH (WIDTH)
  ) u_prox (
    .en_i        (en_i),
    .modo_i      (modo_i),
    .lim_min_i   (lim_min_i),
    .lim_max_i   (lim_max_i),
    .saida_i     (saida_q),
    .sentido_i   (sentido_q),
    .saida_d_o   (saida_d),
    .sentido_d_o (sentido_d),
    .limite_d_o  (limite_d)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      saida_q   <= '0;
      sentido_q <= SENTIDO_CRESC;
      limite_q  <= 1'b0;
    end else begin
`ifdef CONTADOR_CARGA_EN
      if (carga_i) begin
        // Load keeps the direction; range is re-checked on the next step
        saida_q  <= valor_carga_i;
        limite_q <= 1'b0;
      end else begin
        saida_q   <= saida_d;
        sentido_q <= sentido_d;
        limite_q  <= limite_d;
      end
`else
      saida_q   <= saida_d;
      sentido_q <= sentido_d;
      limite_q  <= limite_d;
`endif
    end
  end

  assign saida_o   = saida_q;
  assign sentido_o = sentido_q;
  assign limite_o  = limite_q;

endmodule

`default_nettype wire

// File: tb/tb_contador_vaivem_param.sv
// ============================================================================
// Module      : tb_contador_vaivem_param
// Description : Self-checking bench for contador_vaivem_param (WIDTH=4).
//               Directed steps push their expected registered outputs into
//               a queue; a monitor pops one entry after each rising edge
//               and compares it with the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_contador_vaivem_param;

  localparam int WIDTH = 4;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             d;
    logic             l;
    string            tag;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             carga;
  logic [WIDTH-1:0] valor_carga;
  logic             en;
  logic [1:0]       modo;
  logic [WIDTH-1:0] lim_min;
  logic [WIDTH-1:0] lim_max;
  logic [WIDTH-1:0] saida;
  logic             sentido;
  logic             limite;

  exp_t q[$];
  exp_t mv;
  int   checks = 0;
  int   errors = 0;

  contador_vaivem_param #(
    .WIDTH (WIDTH)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
`ifdef CONTADOR_CARGA_EN
    .carga_i       (carga),
    .valor_carga_i (valor_carga),
`endif
    .en_i          (en),
    .modo_i        (modo),
    .lim_min_i     (lim_min),
    .lim_max_i     (lim_max),
    .saida_o       (saida),
    .sentido_o     (sentido),
    .limite_o      (limite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] es,
                       input logic ed, input logic el);
    checks++;
    if (saida !== es || sentido !== ed || limite !== el) begin
      errors++;
      $display("FAIL %s: got saida=%0d sentido=%0b limite=%0b, expected saida=%0d sentido=%0b limite=%0b",
               tag, saida, sentido, limite, es, ed, el);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge
  task automatic step(input logic e, input logic [1:0] m,
                      input logic [WIDTH-1:0] mn, input logic [WIDTH-1:0] mx,
                      input logic [WIDTH-1:0] es, input logic ed,
                      input logic el, input string tag);
    exp_t v;
    en      = e;
    modo    = m;
    lim_min = mn;
    lim_max = mx;
    v.s = es; v.d = ed; v.l = el; v.tag = tag;
    q.push_back(v);
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare after every rising edge that has an expectation queued
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        mv = q.pop_front();
        check(mv.tag, mv.s, mv.d, mv.l);
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    carga       = 1'b0;
    valor_carga = '0;
    en          = 1'b0;
    modo        = 2'b00;
    lim_min     = 4'd0;
    lim_max     = 4'd15;
    repeat (2) @(posedge clk);
    #3;
    check("reset", 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Bounce over the full range
    for (int i = 1; i <= 15; i++)
      step(1, 2'b00, 4'd0, 4'd15, 4'(i), (i == 15), (i == 15), "bounce_up");
    for (int i = 14; i >= 0; i--)
      step(1, 2'b00, 4'd0, 4'd15, 4'(i), (i != 0), (i == 0), "bounce_down");
    step(1, 2'b00, 4'd0, 4'd15, 4'd1, 1'b0, 1'b0, "bounce_again");

    // Up-wrap 3..6 from 1 (out of range)
    step(1, 2'b01, 4'd3, 4'd6, 4'd3, 1'b0, 1'b0, "upwrap_fix");
    step(1, 2'b01, 4'd3, 4'd6, 4'd4, 1'b0, 1'b0, "upwrap_4");
    step(1, 2'b01, 4'd3, 4'd6, 4'd5, 1'b0, 1'b0, "upwrap_5");
    step(1, 2'b01, 4'd3, 4'd6, 4'd6, 1'b0, 1'b1, "upwrap_top");
    step(1, 2'b01, 4'd3, 4'd6, 4'd3, 1'b0, 1'b0, "upwrap_wrap");
    step(1, 2'b01, 4'd3, 4'd6, 4'd4, 1'b0, 1'b0, "upwrap_4b");

    // Down-wrap: 4 is outside 5..6, snaps to 6; then range 3..6
    step(1, 2'b10, 4'd5, 4'd6, 4'd6, 1'b1, 1'b0, "downwrap_fix");
    step(1, 2'b10, 4'd3, 4'd6, 4'd5, 1'b1, 1'b0, "downwrap_5");
    step(1, 2'b10, 4'd3, 4'd6, 4'd4, 1'b1, 1'b0, "downwrap_4");
    step(1, 2'b10, 4'd3, 4'd6, 4'd3, 1'b1, 1'b1, "downwrap_bot");
    step(1, 2'b10, 4'd3, 4'd6, 4'd6, 1'b1, 1'b0, "downwrap_wrap");

    // Freeze with en low, then with modo=11, then resume bouncing
    for (int i = 0; i < 3; i++)
      step(0, 2'b00, 4'd3, 4'd6, 4'd6, 1'b1, 1'b0, "en_low_hold");
    for (int i = 0; i < 2; i++)
      step(1, 2'b11, 4'd3, 4'd6, 4'd6, 1'b1, 1'b0, "stop_hold");
    step(1, 2'b00, 4'd3, 4'd6, 4'd5, 1'b1, 1'b0, "resume_5");
    step(1, 2'b00, 4'd3, 4'd6, 4'd4, 1'b1, 1'b0, "resume_4");
    step(1, 2'b00, 4'd3, 4'd6, 4'd3, 1'b0, 1'b1, "resume_bot");
    step(1, 2'b00, 4'd3, 4'd6, 4'd4, 1'b0, 1'b0, "resume_turn");

    // Inverted limits collapse onto 9
    step(1, 2'b00, 4'd9, 4'd2, 4'd9, 1'b0, 1'b0, "degen_fix");
    for (int i = 0; i < 3; i++)
      step(1, 2'b00, 4'd9, 4'd2, 4'd9, 1'b0, 1'b1, "degen_hold");

    // Climb to 12, then pulse reset between edges
    step(1, 2'b00, 4'd0, 4'd15, 4'd10, 1'b0, 1'b0, "climb_10");
    step(1, 2'b00, 4'd0, 4'd15, 4'd11, 1'b0, 1'b0, "climb_11");
    step(1, 2'b00, 4'd0, 4'd15, 4'd12, 1'b0, 1'b0, "climb_12");
    #1 rst_n = 1'b0;
    #1 check("async_reset", 4'd0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    step(1, 2'b00, 4'd0, 4'd15, 4'd1, 1'b0, 1'b0, "after_reset");

`ifdef CONTADOR_CARGA_EN
    carga       = 1'b1;
    valor_carga = 4'd14;
    step(1, 2'b00, 4'd0, 4'd15, 4'd14, 1'b0, 1'b0, "load_14");
    carga = 1'b0;
    step(1, 2'b00, 4'd0, 4'd15, 4'd15, 1'b1, 1'b1, "after_load");
`endif

    // Bounded drain of any outstanding expectation
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
